// File: rtl/axi_lite_read_master_pkg.sv
// Shared types and constants for the AXI4-Lite read master and its load-extend datapath.
// Optional build macro used by the top: AXI_RD_ALIGN_CHECK_EN.
package axi_lite_read_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  // Size code 3 is handled like a word everywhere, so it shares the word rule here.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic result;
    case (size)
      SZ_B:    result = 1'b0;
      SZ_H:    result = offset[0];
      default: result = (offset != 2'b00);
    endcase
    return result;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load shaper: aligns the selected byte lanes to bit 0 and zero/sign-extends them.
// Kept standalone so the store path can mirror it.
module load_extend
  import axi_lite_read_master_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Lanes shifted past lane 3 fill with zeros before extension.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (size)
      SZ_B:    result = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SZ_H:    result = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/axi_lite_read_master.sv
// Single-outstanding AXI4-Lite read master turning core load requests into one AR/R exchange.
// Define AXI_RD_ALIGN_CHECK_EN to reject misaligned loads locally without bus traffic.
module axi_lite_read_master
  import axi_lite_read_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_axi_araddr,
  output logic              o_axi_arvalid,
  input  logic              i_axi_arready,
  input  logic [DATA_W-1:0] i_axi_rdata,
  input  logic              i_axi_rvalid,
  input  logic [1:0]        i_axi_rresp,
  output logic              o_axi_rready
);

  state_t      state;
  state_t      state_next;
  logic [1:0]  lat_offset;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic        req_accept;
  logic        req_misaligned;
  logic [31:0] extended;

  load_extend u_load_extend (
    .rdata     (i_axi_rdata),
    .offset    (lat_offset),
    .size      (lat_size),
    .is_signed (lat_signed),
    .result    (extended)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake outputs are pure state decodes, so no input reaches an output combinationally.
  always_comb begin
    state_next     = state;
    o_req_ready    = 1'b0;
    o_axi_arvalid  = 1'b0;
    o_axi_rready   = 1'b0;
    o_rsp_valid    = 1'b0;
    req_accept     = 1'b0;
`ifdef AXI_RD_ALIGN_CHECK_EN
    req_misaligned = is_misaligned(i_req_size, i_req_addr[1:0]);
`else
    req_misaligned = 1'b0;
`endif
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          req_accept = 1'b1;
          state_next = req_misaligned ? RESP : ADDR;
        end
      end
      ADDR: begin
        o_axi_arvalid = 1'b1;
        if (i_axi_arready) state_next = DATA;
      end
      DATA: begin
        o_axi_rready = 1'b1;
        if (i_axi_rvalid) state_next = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured only on acceptance; response fields only on the R beat
  // (or on a local alignment rejection) and then held through RESP.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_axi_araddr <= '0;
      o_rsp_data   <= '0;
      o_rsp_err    <= 1'b0;
      lat_offset   <= 2'b00;
      lat_size     <= SZ_B;
      lat_signed   <= 1'b0;
    end else begin
      if (req_accept) begin
        o_axi_araddr <= {i_req_addr[ADDR_W-1:2], 2'b00};
        lat_offset   <= i_req_addr[1:0];
        lat_size     <= i_req_size;
        lat_signed   <= i_req_signed;
        if (req_misaligned) begin
          o_rsp_data <= '0;
          o_rsp_err  <= 1'b1;
        end
      end
      if (state == DATA && i_axi_rvalid) begin
        o_rsp_err  <= (i_axi_rresp != OKAY);
        o_rsp_data <= (i_axi_rresp != OKAY) ? '0 : extended;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_read_master.sv
// Directed self-checking bench for axi_lite_read_master with a configurable-latency AXI slave.
// Follows the DUT build: define AXI_RD_ALIGN_CHECK_EN for both to exercise local alignment rejection.
module tb_axi_lite_read_master;

  logic        i_clock;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [1:0]  i_req_size;
  logic        i_req_signed;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;
  logic [31:0] o_axi_araddr;
  logic        o_axi_arvalid;
  logic        i_axi_arready;
  logic [31:0] i_axi_rdata;
  logic        i_axi_rvalid;
  logic [1:0]  i_axi_rresp;
  logic        o_axi_rready;

  int tests_run    = 0;
  int tests_failed = 0;

  // Slave configuration and bus monitor state
  logic        slave_en = 1'b1;
  int          ar_delay = 0;
  int          r_delay  = 0;
  logic [31:0] s_rdata  = 32'h0;
  logic [1:0]  s_rresp  = 2'b00;
  int          ar_cnt   = 0;
  int          r_cnt    = 0;
  int          ar_hs    = 0;
  int          r_hs     = 0;
  int          stab_err = 0;
  logic        ar_pend  = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] last_araddr = 32'h0;

  axi_lite_read_master dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_addr    (i_req_addr),
    .i_req_size    (i_req_size),
    .i_req_signed  (i_req_signed),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_data    (o_rsp_data),
    .o_rsp_err     (o_rsp_err),
    .o_axi_araddr  (o_axi_araddr),
    .o_axi_arvalid (o_axi_arvalid),
    .i_axi_arready (i_axi_arready),
    .i_axi_rdata   (i_axi_rdata),
    .i_axi_rvalid  (i_axi_rvalid),
    .i_axi_rresp   (i_axi_rresp),
    .o_axi_rready  (o_axi_rready)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Counts handshakes and flags any AR request that drops or changes address before arready.
  always @(posedge i_clock) begin
    if (!i_reset && ar_pend && (!o_axi_arvalid || o_axi_araddr !== pend_addr)) stab_err++;
    ar_pend   = o_axi_arvalid && !i_axi_arready;
    pend_addr = o_axi_araddr;
    if (o_axi_arvalid && i_axi_arready) begin
      ar_hs++;
      last_araddr = o_axi_araddr;
    end
    if (i_axi_rvalid && o_axi_rready) r_hs++;
  end

  // Slave model: raises arready/rvalid after the configured number of waiting cycles.
  initial begin
    forever begin
      @(posedge i_clock);
      #1;
      if (slave_en) begin
        if (i_axi_arready && !o_axi_arvalid) begin
          i_axi_arready = 1'b0;
          ar_cnt = 0;
        end else if (o_axi_arvalid && !i_axi_arready) begin
          if (ar_cnt >= ar_delay) i_axi_arready = 1'b1;
          else ar_cnt++;
        end
        if (i_axi_rvalid && !o_axi_rready) begin
          i_axi_rvalid = 1'b0;
          r_cnt = 0;
        end else if (o_axi_rready && !i_axi_rvalid) begin
          if (r_cnt >= r_delay) begin
            i_axi_rvalid = 1'b1;
            i_axi_rdata  = s_rdata;
            i_axi_rresp  = s_rresp;
          end else begin
            r_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Presents one request, then scrambles the request lines; lat counts edges from
  // presentation until rsp_valid is seen (-1 if it never arrives).
  task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic sg, output int lat);
    i_req_valid  = 1'b1;
    i_req_addr   = a;
    i_req_size   = sz;
    i_req_signed = sg;
    lat = 0;
    do begin
      @(posedge i_clock);
      #1;
      i_req_valid  = 1'b0;
      i_req_addr   = 32'hFFFF_FFFF;
      i_req_size   = 2'd0;
      i_req_signed = ~sg;
      lat++;
    end while (!o_rsp_valid && lat < 60);
    if (!o_rsp_valid) lat = -1;
  endtask

  task automatic release_rsp();
    i_rsp_ready = 1'b1;
    @(posedge i_clock);
    #1;
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    @(posedge i_clock);
    #1;
    tests_run++;
    if (o_axi_arvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_arvalid: got %b expected 0", o_axi_arvalid); end
    tests_run++;
    if (o_axi_rready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rready: got %b expected 0", o_axi_rready); end
    tests_run++;
    if (o_rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", o_rsp_valid); end
    tests_run++;
    if (o_rsp_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rsp_data: got %h expected 00000000", o_rsp_data); end
    tests_run++;
    if (o_rsp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", o_rsp_err); end
    tests_run++;
    if (o_axi_araddr !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_araddr: got %h expected 00000000", o_axi_araddr); end
    tests_run++;
    if (o_req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %b expected 1", o_req_ready); end
  endtask

  task automatic test_word_load();
    int lat;
    int ar0, r0;
    ar0 = ar_hs; r0 = r_hs;
    s_rdata = 32'h1234_5678; s_rresp = 2'b00;
    issue(32'h8000_0004, 2'd2, 1'b0, lat);
    // Request cycle plus ADDR and DATA: rsp_valid visible three edges after presentation.
    tests_run++;
    if (lat != 3) begin tests_failed++; $display("[TB] FAIL word_latency: got %0d expected 3", lat); end
    tests_run++;
    if (last_araddr !== 32'h8000_0004) begin tests_failed++; $display("[TB] FAIL word_araddr: got %h expected 80000004", last_araddr); end
    tests_run++;
    if (o_rsp_data !== 32'h1234_5678) begin tests_failed++; $display("[TB] FAIL word_data: got %h expected 12345678", o_rsp_data); end
    tests_run++;
    if (o_rsp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL word_err: got %b expected 0", o_rsp_err); end
    tests_run++;
    if ((ar_hs - ar0) != 1 || (r_hs - r0) != 1) begin
      tests_failed++; $display("[TB] FAIL word_handshakes: got ar=%0d r=%0d expected 1/1", ar_hs - ar0, r_hs - r0);
    end
    release_rsp();
  endtask

  task automatic test_sign_byte();
    int lat;
    s_rdata = 32'h80FF_FFFF; s_rresp = 2'b00;
    issue(32'h0000_0003, 2'd0, 1'b1, lat);
    tests_run++;
    if (o_rsp_data !== 32'hFFFF_FF80) begin tests_failed++; $display("[TB] FAIL byte_signed: got %h expected ffffff80", o_rsp_data); end
    tests_run++;
    if (last_araddr !== 32'h0000_0000) begin tests_failed++; $display("[TB] FAIL byte_araddr: got %h expected 00000000", last_araddr); end
    release_rsp();
    issue(32'h0000_0003, 2'd0, 1'b0, lat);
    tests_run++;
    if (o_rsp_data !== 32'h0000_0080) begin tests_failed++; $display("[TB] FAIL byte_unsigned: got %h expected 00000080", o_rsp_data); end
    release_rsp();
    s_rdata = 32'h8001_1234;
    issue(32'h0000_0102, 2'd1, 1'b1, lat);
    tests_run++;
    if (o_rsp_data !== 32'hFFFF_8001) begin tests_failed++; $display("[TB] FAIL half_signed_hi: got %h expected ffff8001", o_rsp_data); end
    release_rsp();
    issue(32'h0000_0100, 2'd1, 1'b1, lat);
    tests_run++;
    if (o_rsp_data !== 32'h0000_1234) begin tests_failed++; $display("[TB] FAIL half_signed_lo: got %h expected 00001234", o_rsp_data); end
    release_rsp();
  endtask

  task automatic test_wait_states();
    int lat;
    int ar0, r0, st0;
    ar0 = ar_hs; r0 = r_hs; st0 = stab_err;
    ar_delay = 4; r_delay = 3;
    s_rdata = 32'hCAFE_F00D; s_rresp = 2'b00;
    issue(32'h1000_0008, 2'd3, 1'b0, lat);
    tests_run++;
    if (stab_err != st0) begin tests_failed++; $display("[TB] FAIL wait_ar_stable: got %0d violations expected 0", stab_err - st0); end
    tests_run++;
    if ((ar_hs - ar0) != 1) begin tests_failed++; $display("[TB] FAIL wait_ar_count: got %0d expected 1", ar_hs - ar0); end
    tests_run++;
    if ((r_hs - r0) != 1) begin tests_failed++; $display("[TB] FAIL wait_r_count: got %0d expected 1", r_hs - r0); end
    tests_run++;
    if (o_rsp_data !== 32'hCAFE_F00D || last_araddr !== 32'h1000_0008) begin
      tests_failed++; $display("[TB] FAIL wait_data: got %h @%h expected cafef00d @10000008", o_rsp_data, last_araddr);
    end
    release_rsp();
    ar_delay = 0; r_delay = 0;
  endtask

  task automatic test_slverr();
    int lat;
    s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b10;
    issue(32'h0000_0040, 2'd2, 1'b0, lat);
    tests_run++;
    if (o_rsp_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL slverr_err: got %b expected 1", o_rsp_err); end
    tests_run++;
    if (o_rsp_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL slverr_data: got %h expected 00000000", o_rsp_data); end
    release_rsp();
    s_rresp = 2'b00;
  endtask

  task automatic test_rsp_hold();
    int lat;
    int ar0, bad;
    s_rdata = 32'h0BAD_F00D;
    issue(32'h2000_0010, 2'd2, 1'b0, lat);
    ar0 = ar_hs;
    bad = 0;
    i_req_valid = 1'b1;
    i_req_addr  = 32'h2000_0020;
    i_req_size  = 2'd2;
    repeat (5) begin
      @(posedge i_clock);
      #1;
      if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h0BAD_F00D || o_req_ready !== 1'b0) bad++;
    end
    i_req_valid = 1'b0;
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("[TB] FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
    tests_run++;
    if (ar_hs != ar0) begin tests_failed++; $display("[TB] FAIL hold_no_new_ar: got %0d expected 0", ar_hs - ar0); end
    release_rsp();
    tests_run++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL hold_release: got ready=%b valid=%b expected 1/0", o_req_ready, o_rsp_valid);
    end
    s_rdata = 32'h600D_CAFE;
    issue(32'h2000_0014, 2'd2, 1'b0, lat);
    tests_run++;
    if (lat != 3 || o_rsp_data !== 32'h600D_CAFE) begin
      tests_failed++; $display("[TB] FAIL hold_next_req: got lat=%0d data=%h expected 3/600dcafe", lat, o_rsp_data);
    end
    release_rsp();
  endtask

  task automatic test_misaligned();
    int lat;
    int ar0;
    ar0 = ar_hs;
`ifdef AXI_RD_ALIGN_CHECK_EN
    issue(32'h4000_0002, 2'd2, 1'b0, lat);
    tests_run++;
    if (lat != 1 || o_rsp_err !== 1'b1 || o_rsp_data !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL misalign_reject: got lat=%0d err=%b data=%h expected 1/1/00000000", lat, o_rsp_err, o_rsp_data);
    end
    tests_run++;
    if (ar_hs != ar0) begin tests_failed++; $display("[TB] FAIL misalign_no_ar: got %0d expected 0", ar_hs - ar0); end
    release_rsp();
    s_rdata = 32'h80FF_FFFF;
    issue(32'h4000_0003, 2'd0, 1'b1, lat);
    tests_run++;
    if (o_rsp_err !== 1'b0 || o_rsp_data !== 32'hFFFF_FF80) begin
      tests_failed++; $display("[TB] FAIL misalign_byte_ok: got err=%b data=%h expected 0/ffffff80", o_rsp_err, o_rsp_data);
    end
    release_rsp();
`else
    s_rdata = 32'hAABB_CCDD;
    issue(32'h4000_0001, 2'd2, 1'b0, lat);
    tests_run++;
    if (o_rsp_data !== 32'h00AA_BBCC || o_rsp_err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL misalign_word: got err=%b data=%h expected 0/00aabbcc", o_rsp_err, o_rsp_data);
    end
    tests_run++;
    if (last_araddr !== 32'h4000_0000 || (ar_hs - ar0) != 1) begin
      tests_failed++; $display("[TB] FAIL misalign_araddr: got %h n=%0d expected 40000000 n=1", last_araddr, ar_hs - ar0);
    end
    release_rsp();
    s_rdata = 32'h80FF_FFFF;
    issue(32'h4000_0003, 2'd1, 1'b1, lat);
    tests_run++;
    if (o_rsp_data !== 32'h0000_0080) begin tests_failed++; $display("[TB] FAIL misalign_half: got %h expected 00000080", o_rsp_data); end
    release_rsp();
`endif
  endtask

  task automatic test_reset_mid();
    int lat;
    int r0, ar0, bad;
    slave_en = 1'b0;
    i_axi_arready = 1'b0;
    i_axi_rvalid  = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = 32'h3000_0000;
    i_req_size  = 2'd2;
    @(posedge i_clock);
    #1;
    i_req_valid   = 1'b0;
    i_axi_arready = 1'b1;
    @(posedge i_clock);
    #1;
    i_axi_arready = 1'b0;
    tests_run++;
    if (o_axi_rready !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_in_data: got rready=%b expected 1", o_axi_rready); end
    i_reset = 1'b1;
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    tests_run++;
    if (o_axi_rready !== 1'b0 || o_axi_arvalid !== 1'b0 || o_req_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL mid_reset_idle: got rready=%b arvalid=%b req_ready=%b expected 0/0/1", o_axi_rready, o_axi_arvalid, o_req_ready);
    end
    r0 = r_hs;
    bad = 0;
    i_axi_rvalid = 1'b1;
    i_axi_rdata  = 32'h55AA_55AA;
    i_axi_rresp  = 2'b00;
    repeat (3) begin
      @(posedge i_clock);
      #1;
      if (o_axi_rready !== 1'b0 || o_rsp_valid !== 1'b0) bad++;
    end
    i_axi_rvalid = 1'b0;
    tests_run++;
    if (bad != 0 || r_hs != r0) begin
      tests_failed++; $display("[TB] FAIL mid_late_beat: got %0d bad cycles %0d beats expected 0/0", bad, r_hs - r0);
    end
    ar_cnt = 0; r_cnt = 0;
    slave_en = 1'b1;
    ar0 = ar_hs;
`ifdef AXI_RD_ALIGN_CHECK_EN
    issue(32'h0000_0001, 2'd1, 1'b0, lat);
    tests_run++;
    if (o_rsp_err !== 1'b1 || o_rsp_data !== 32'h0 || ar_hs != ar0) begin
      tests_failed++; $display("[TB] FAIL mid_followup: got err=%b data=%h ar=%0d expected 1/00000000/0", o_rsp_err, o_rsp_data, ar_hs - ar0);
    end
`else
    s_rdata = 32'h1357_9BDF;
    issue(32'h3000_0004, 2'd2, 1'b0, lat);
    tests_run++;
    if (lat != 3 || o_rsp_data !== 32'h1357_9BDF || o_rsp_err !== 1'b0 || (ar_hs - ar0) != 1) begin
      tests_failed++; $display("[TB] FAIL mid_followup: got lat=%0d data=%h err=%b expected 3/13579bdf/0", lat, o_rsp_data, o_rsp_err);
    end
`endif
    release_rsp();
  endtask

  initial begin
    i_reset       = 1'b1;
    i_req_valid   = 1'b0;
    i_req_addr    = 32'h0;
    i_req_size    = 2'd0;
    i_req_signed  = 1'b0;
    i_rsp_ready   = 1'b0;
    i_axi_arready = 1'b0;
    i_axi_rdata   = 32'h0;
    i_axi_rvalid  = 1'b0;
    i_axi_rresp   = 2'b00;

    test_reset();
    test_word_load();
    test_sign_byte();
    test_wait_states();
    test_slverr();
    test_rsp_hold();
    test_misaligned();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_lite_read_master.md
Name: axi_lite_read_master

Overview:
- Single-outstanding AXI4-Lite read initiator, the master side of the AR/R channels.
- Core side: an LSU/IFU load request (address, size, signedness) is converted into one AXI read.
- Returned beat is byte-lane aligned, then zero- or sign-extended, and presented on a valid/ready response port.
- Sits between the core's memory stage and the interconnect feeding peripherals such as the timer.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width; fixed to 32 (byte-lane logic assumes 4 lanes).

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  core load request valid
- o_req_ready  out  1  master can accept a request
- i_req_addr  in  32  byte address
- i_req_size  in  2  0=byte, 1=half, 2=word (3 treated as word)
- i_req_signed  in  1  1=sign-extend, 0=zero-extend
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  core accepts response
- o_rsp_data  out  32  extended load data
- o_rsp_err  out  1  bus or alignment error
- o_axi_araddr  out  32  read address
- o_axi_arvalid  out  1  read address valid
- i_axi_arready  in  1  read address ready
- i_axi_rdata  in  32  read data
- i_axi_rvalid  in  1  read data valid
- i_axi_rresp  in  2  read response
- o_axi_rready  out  1  read data ready

Behaviour:
- FSM states: IDLE, ADDR, DATA, RESP. All outputs are registered or decoded from state only; no combinational in-to-out paths.
- Reset: state=IDLE, o_axi_arvalid=0, o_axi_rready=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_axi_araddr=0.
- o_req_ready = (state==IDLE).
- IDLE: on i_req_valid, latch addr/size/signed.
  - o_axi_araddr = {addr[31:2],2'b00} (word-aligned).
  - Go to ADDR; o_axi_arvalid=1 from the next cycle.
- ADDR: hold arvalid and araddr stable until i_axi_arready; arvalid must not drop early.
  - On arvalid&&arready: arvalid←0, rready←1, go to DATA.
  - arready may already be high when arvalid rises, giving a 1-cycle ADDR.
- DATA: rready=1. On i_axi_rvalid, latch data and err, rready←0, go to RESP.
  - rvalid arriving in the first DATA cycle is accepted.
- RESP: o_rsp_valid=1, data/err held stable until i_rsp_ready; then go to IDLE.
  - No new request is accepted in the same cycle (one bubble).
- Minimum latency: request accept → o_rsp_valid = 3 cycles with zero-wait slave.
- Data shaping on capture:
  - shifted = rdata >> (8*addr[1:0]).
  - Byte: low 8 bits, extended per signed. Half: low 16 bits, extended per signed. Word: shifted unchanged.
- Error handling: i_axi_rresp != 0 gives o_rsp_err=1 and o_rsp_data=0.
- Misaligned access (half at addr[0]=1, word at addr[1:0]!=0), without the optional feature:
  - Still issued.
  - Bytes shifted past lane 3 read as zero before extension.
- Reset mid-transaction: FSM returns to IDLE immediately with arvalid/rready low.
  - Any late R beat from the slave is never accepted, since rready stays low until a new ADDR handshake completes.
- Input changes on i_req_* outside an accepted IDLE cycle are ignored.

Optional Feature:
- Macro AXI_RD_ALIGN_CHECK_EN.
- Defined: a misaligned request is accepted in IDLE but no AXI traffic is generated. FSM goes directly to RESP with o_rsp_err=1, o_rsp_data=0; latency 1 cycle.
- Undefined: no alignment check; behaviour as in Behaviour.

Decomposition:
- Shared package holds:
  - state enum (IDLE/ADDR/DATA/RESP);
  - size constants (SZ_B=0, SZ_H=1, SZ_W=2);
  - AXI resp constants (OKAY=0, SLVERR=2, DECERR=3).
- One natural sub-module, load_extend: combinational shift/mask/extend from (rdata, addr[1:0], size, signed) to 32-bit result. Reusable by the store-path mirror.

Test Plan:
- Zero-wait slave, word load addr 0x8000_0004, rdata 0x1234_5678:
  - araddr=0x8000_0004.
  - rsp_data=0x1234_5678, err=0, rsp_valid 3 cycles after accept.
- Signed byte load addr 0x...03, rdata 0x80FF_FFFF → rsp_data=0xFFFF_FF80. Same with signed=0 → 0x0000_0080.
- arready delayed 4 cycles and rvalid delayed 3 cycles:
  - arvalid/araddr stable throughout.
  - Exactly one AR and one R handshake.
  - Correct data.
- rresp=2'b10 with rdata 0xDEAD_BEEF → rsp_err=1, rsp_data=0.
- i_rsp_ready held low 5 cycles: rsp_valid/data stable, req_ready=0. Release → IDLE next cycle, new request accepted.
- Reset asserted in DATA, then slave drives rvalid: rready=0, no response issued. A following request completes normally (with AXI_RD_ALIGN_CHECK_EN: half at addr 0x1 → err=1, no arvalid).
